mc_control: RTL and testbench

Multi-cycle control FSM that drives the ALU's 2-bit `aluop` and consumes its `zero` flag. It sequences the shared datapath (PC, IR, register file, unified memory, ALU) through fetch, decode, execute, memory and write-back. It decodes the MIPS subset addu/subu/or, lw, sw, ori, beq and j. Instruction and data accesses share one memory port and stall on a ready handshake.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_control_alu_op_dec.sv | 22 ++
 rtl/mc_control.sv | 171 +++++++++++++++++
 tb/tb_mc_control.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control path.
// The TRAP state exists only when MC_CONTROL_ILLEGAL_TRAP_EN is defined.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_ORIEX,
    S_ORIWB,
    S_BRANCH,
    S_JUMP
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_alu_op_dec.sv
// R-type funct decoder: funct -> {aluop, legal}; purely combinational, no flow control.
// Shared by the DECODE legality check and the EXEC aluop selection.
module alu_op_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [1:0] aluop,
  output logic       legal
);

  always_comb begin
    aluop = ALUOP_ADD;
    legal = 1'b1;
    case (funct)
      FUNCT_ADDU: aluop = ALUOP_ADD;
      FUNCT_SUBU: aluop = ALUOP_SUB;
      FUNCT_OR:   aluop = ALUOP_OR;
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM (lw 5, sw/R/ori 4, beq/j 3 cycles); FETCH/MEMRD/MEMWR stall on mem_rdy_i.
// MC_CONTROL_ILLEGAL_TRAP_EN adds a sticky TRAP state and illegal_o; otherwise illegal ops act as NOPs.
module mc_control
  import mc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_rdy_i,
  output logic       pc_we_o,
  output logic       ir_we_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       rf_we_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic       extop_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pcsrc_o
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_o
`endif
);

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_TRAP;
`else
  localparam state_t S_ILL = S_FETCH;
`endif

  state_t     state, state_nxt;
  logic [1:0] funct_aluop;
  logic       funct_legal;

  alu_op_dec u_alu_op_dec (
    .funct (funct_i),
    .aluop (funct_aluop),
    .legal (funct_legal)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (mem_rdy_i) state_nxt = S_DECODE;
      S_DECODE: begin
        case (op_i)
          OP_RTYPE:     state_nxt = funct_legal ? S_EXEC : S_ILL;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_ORI:       state_nxt = S_ORIEX;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_ILL;
        endcase
      end
      S_MEMADR: state_nxt = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy_i) state_nxt = S_MEMWB;
      S_MEMWB:  state_nxt = S_FETCH;
      S_MEMWR:  if (mem_rdy_i) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ALUWB:  state_nxt = S_FETCH;
      S_ORIEX:  state_nxt = S_ORIWB;
      S_ORIWB:  state_nxt = S_FETCH;
      S_BRANCH: state_nxt = S_FETCH;
      S_JUMP:   state_nxt = S_FETCH;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP:   state_nxt = S_TRAP;
`endif
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we_o    = 1'b0;
    ir_we_o    = 1'b0;
    mem_we_o   = 1'b0;
    iord_o     = 1'b0;
    rf_we_o    = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_REG;
    extop_o    = 1'b0;
    aluop_o    = ALUOP_ADD;
    pcsrc_o    = PCSRC_ALU;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    illegal_o  = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        alusrcb_o = SRCB_FOUR;
        ir_we_o   = mem_rdy_i;
        pc_we_o   = mem_rdy_i;
      end
      S_DECODE: begin
        alusrcb_o = SRCB_BOFF;
        extop_o   = 1'b1;
      end
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        extop_o   = 1'b1;
      end
      S_MEMRD: iord_o = 1'b1;
      S_MEMWB: begin
        rf_we_o    = 1'b1;
        memtoreg_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o   = 1'b1;
        mem_we_o = 1'b1;
      end
      S_EXEC: begin
        alusrca_o = 1'b1;
        aluop_o   = funct_aluop;
      end
      S_ALUWB: begin
        rf_we_o  = 1'b1;
        regdst_o = 1'b1;
      end
      S_ORIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        aluop_o   = ALUOP_OR;
      end
      S_ORIWB: rf_we_o = 1'b1;
      S_BRANCH: begin
        alusrca_o = 1'b1;
        aluop_o   = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        pc_we_o   = zero_i;
      end
      S_JUMP: begin
        pcsrc_o = PCSRC_JUMP;
        pc_we_o = 1'b1;
      end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP: illegal_o = 1'b1;
`endif
      default: ;
    endcase
    // Reset masks everything so an abandoned instruction cannot leak a write.
    if (rst_i) begin
      pc_we_o    = 1'b0;
      ir_we_o    = 1'b0;
      mem_we_o   = 1'b0;
      iord_o     = 1'b0;
      rf_we_o    = 1'b0;
      regdst_o   = 1'b0;
      memtoreg_o = 1'b0;
      alusrca_o  = 1'b0;
      alusrcb_o  = SRCB_REG;
      extop_o    = 1'b0;
      aluop_o    = ALUOP_ADD;
      pcsrc_o    = PCSRC_ALU;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      illegal_o  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: random instruction streams with random memory wait states,
// checked every cycle against per-instruction expected control-word sequences.
module tb_mc_control;

  typedef struct packed {
    logic       ill;
    logic       pc_we;
    logic       ir_we;
    logic       mem_we;
    logic       iord;
    logic       rf_we;
    logic       regdst;
    logic       memtoreg;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic [1:0] aop;
    logic [1:0] pcs;
  } cw_t;

  localparam int K_LW = 0, K_SW = 1, K_ADDU = 2, K_SUBU = 3, K_OR = 4,
                 K_ORI = 5, K_BEQ = 6, K_J = 7, K_BADOP = 8, K_BADFN = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_rdy;
  logic       pc_we, ir_we, mem_we, iord, rf_we, regdst, memtoreg, alusrca, extop;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       illegal;
  cw_t        obs;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  mc_control dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .op_i       (op),
    .funct_i    (funct),
    .zero_i     (zero),
    .mem_rdy_i  (mem_rdy),
    .pc_we_o    (pc_we),
    .ir_we_o    (ir_we),
    .mem_we_o   (mem_we),
    .iord_o     (iord),
    .rf_we_o    (rf_we),
    .regdst_o   (regdst),
    .memtoreg_o (memtoreg),
    .alusrca_o  (alusrca),
    .alusrcb_o  (alusrcb),
    .extop_o    (extop),
    .aluop_o    (aluop),
    .pcsrc_o    (pcsrc)
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    ,
    .illegal_o  (illegal)
`endif
  );

`ifndef MC_CONTROL_ILLEGAL_TRAP_EN
  assign illegal = 1'b0;
`endif

  assign obs = {illegal, pc_we, ir_we, mem_we, iord, rf_we, regdst, memtoreg,
                alusrca, alusrcb, extop, aluop, pcsrc};

  task automatic check(input string tag, input cw_t got, input cw_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs just after the edge, compare at the falling edge.
  task automatic cyc(input string tag, input logic rdy, input logic z, input cw_t exp);
    mem_rdy = rdy;
    zero    = z;
    @(negedge clk);
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    cw_t e;
    e = '0;
    e.srcb = 2'b01;
    for (int i = 0; i < waits; i++) cyc("fetch_wait", 1'b0, 1'($urandom), e);
    e.pc_we = 1'b1;
    e.ir_we = 1'b1;
    cyc("fetch_done", 1'b1, 1'($urandom), e);
  endtask

  // A memory access stalls for 'waits' cycles with the request held, then completes.
  task automatic mem_access(input string tag, input int waits, input logic wr);
    cw_t e;
    e = '0;
    e.iord   = 1'b1;
    e.mem_we = wr;
    for (int i = 0; i < waits; i++) cyc(tag, 1'b0, 1'($urandom), e);
    cyc(tag, 1'b1, 1'($urandom), e);
  endtask

  task automatic pick_instr(input int kind);
    logic [5:0] r;
    funct = 6'($urandom);
    case (kind)
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_ADDU: begin op = 6'b000000; funct = 6'b100001; end
      K_SUBU: begin op = 6'b000000; funct = 6'b100011; end
      K_OR:   begin op = 6'b000000; funct = 6'b100101; end
      K_ORI:  op = 6'b001101;
      K_BEQ:  op = 6'b000100;
      K_J:    op = 6'b000010;
      K_BADOP: begin
        r = 6'($urandom);
        while (r == 6'b000000 || r == 6'b100011 || r == 6'b101011 ||
               r == 6'b001101 || r == 6'b000100 || r == 6'b000010)
          r = 6'($urandom);
        op = r;
      end
      default: begin
        op = 6'b000000;
        r  = 6'($urandom);
        while (r == 6'b100001 || r == 6'b100011 || r == 6'b100101) r = 6'($urandom);
        funct = r;
      end
    endcase
  endtask

  task automatic run_instr(input int kind, input int wf, input int wm, input logic bz);
    cw_t e;
    pick_instr(kind);
    fetch(wf);
    e = '0; e.srcb = 2'b11; e.ext = 1'b1;
    cyc("decode", 1'($urandom), 1'($urandom), e);
    case (kind)
      K_LW, K_SW: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
        cyc("memadr", 1'($urandom), 1'($urandom), e);
        if (kind == K_LW) begin
          mem_access("memrd", wm, 1'b0);
          e = '0; e.rf_we = 1'b1; e.memtoreg = 1'b1;
          cyc("memwb", 1'($urandom), 1'($urandom), e);
        end else begin
          mem_access("memwr", wm, 1'b1);
        end
      end
      K_ADDU, K_SUBU, K_OR: begin
        e = '0; e.srca = 1'b1;
        e.aop = (kind == K_ADDU) ? 2'b00 : (kind == K_SUBU) ? 2'b01 : 2'b10;
        cyc("exec", 1'($urandom), 1'($urandom), e);
        e = '0; e.rf_we = 1'b1; e.regdst = 1'b1;
        cyc("aluwb", 1'($urandom), 1'($urandom), e);
      end
      K_ORI: begin
        e = '0; e.srca = 1'b1; e.srcb = 2'b10; e.aop = 2'b10;
        cyc("oriex", 1'($urandom), 1'($urandom), e);
        e = '0; e.rf_we = 1'b1;
        cyc("oriwb", 1'($urandom), 1'($urandom), e);
      end
      K_BEQ: begin
        e = '0; e.srca = 1'b1; e.aop = 2'b01; e.pcs = 2'b01; e.pc_we = bz;
        cyc(bz ? "branch_taken" : "branch_not", 1'($urandom), bz, e);
      end
      K_J: begin
        e = '0; e.pcs = 2'b10; e.pc_we = 1'b1;
        cyc("jump", 1'($urandom), 1'($urandom), e);
      end
      default: ; // illegal without trap: back to FETCH, checked by the next fetch
    endcase
  endtask

  initial begin
    cw_t e;
    int  kind;
    int  nk;
    rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("reset", 1'($urandom), 1'($urandom), '0);
    rst = 1'b0;

    run_instr(K_LW,   0, 0, 1'b0);
    run_instr(K_SW,   0, 3, 1'b0);
    run_instr(K_SUBU, 1, 0, 1'b0);
    run_instr(K_BEQ,  0, 0, 1'b1);
    run_instr(K_BEQ,  0, 0, 1'b0);
    run_instr(K_J,    2, 0, 1'b0);
    run_instr(K_ORI,  0, 0, 1'b0);

    // Reset while stalled in MEMRD: no MEMWB afterwards.
    pick_instr(K_LW);
    fetch(0);
    e = '0; e.srcb = 2'b11; e.ext = 1'b1;
    cyc("decode", 1'b0, 1'b0, e);
    e = '0; e.srca = 1'b1; e.srcb = 2'b10; e.ext = 1'b1;
    cyc("memadr", 1'b0, 1'b0, e);
    rst = 1'b1;
    cyc("rst_in_memrd", 1'b1, 1'b0, '0);
    rst = 1'b0;
    e = '0; e.srcb = 2'b01;
    cyc("after_rst_fetch", 1'b0, 1'b0, e);

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    nk = 8;
`else
    nk = 10;
    run_instr(K_BADOP, 0, 0, 1'b0);
    run_instr(K_BADFN, 0, 0, 1'b0);
`endif
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(nk - 1, 0);
      run_instr(kind, $urandom_range(2, 0), $urandom_range(3, 0), 1'($urandom));
    end

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
    pick_instr(K_BADOP);
    op = 6'b111111;
    fetch(0);
    e = '0; e.srcb = 2'b11; e.ext = 1'b1;
    cyc("decode", 1'b0, 1'b0, e);
    e = '0; e.ill = 1'b1;
    for (int i = 0; i < 10; i++) cyc("trap_hold", 1'($urandom), 1'($urandom), e);
    rst = 1'b1;
    cyc("trap_rst", 1'b1, 1'b1, '0);
    rst = 1'b0;
    run_instr(K_BADFN, 0, 0, 1'b0);
    e = '0; e.ill = 1'b1;
    for (int i = 0; i < 3; i++) cyc("trap_funct", 1'($urandom), 1'($urandom), e);
    rst = 1'b1;
    cyc("trap_rst", 1'b0, 1'b0, '0);
    rst = 1'b0;
`endif
    run_instr(K_LW, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
